// File: rtl/seq_uart_tx_pkg.sv
// Shared constants and FSM state encoding for the sequencer UART transmitter.
package seq_uart_tx_pkg;

  // Default bit period: 100 MHz system clock at 115200 baud.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  // Sequencer datapath width, reused as the UART payload width.
  localparam int unsigned SEQ_DP_WIDTH = 8;

  // Transmitter frame phases.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/seq_uart_baud.sv
// Baud-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses tick_o
// on the last cycle of each bit period, and restarts from zero on clr_i.
module seq_uart_baud
  import seq_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_MAX);

  // Next count: clear wins, wrap at the end of a bit, park at zero when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seq_uart_tx.sv
// Sequencer UART transmitter: accepts one word per valid/busy handshake and
// shifts it out LSB-first on an idle-high line (8N1, or 8E1 when the macro
// SEQ_UART_TX_PARITY_EN is defined).
//
// Handshake: a word is accepted on a rising edge where i_tx_valid=1 and
// o_tx_busy=0. o_tx_busy is a register and never depends on i_tx_valid in
// the same cycle; requests while busy are dropped, not queued.
module seq_uart_tx
  import seq_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_WIDTH   = SEQ_DP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_busy,
  output logic                  o_txd,
  output logic [2:0]            o_dbg_state
);

  localparam int unsigned BCNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [BCNT_W-1:0]     bit_q, bit_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  accept;
  logic                  tick;
`ifdef SEQ_UART_TX_PARITY_EN
  logic [DATA_WIDTH-1:0] data_q, data_d;
`endif

  assign accept      = i_tx_valid && !busy_q;
  assign shift_nxt   = shift_q >> 1;
  assign o_tx_busy   = busy_q;
  assign o_txd       = txd_q;
  assign o_dbg_state = state_q;

  seq_uart_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (busy_q),
    .tick_o(tick)
  );

  // Frame sequencing; line level and busy are computed for the next state so
  // both registers change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    txd_d   = txd_q;
`ifdef SEQ_UART_TX_PARITY_EN
    data_d  = data_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (accept) begin
          shift_d = i_tx_data;
`ifdef SEQ_UART_TX_PARITY_EN
          data_d  = i_tx_data;
`endif
          bit_d   = '0;
          txd_d   = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          txd_d   = shift_q[0];
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == BCNT_LAST) begin
`ifdef SEQ_UART_TX_PARITY_EN
            txd_d   = ^data_q;
            state_d = ST_PARITY;
`else
            txd_d   = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            shift_d = shift_nxt;
            txd_d   = shift_nxt[0];
            bit_d   = bit_q + BCNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          txd_d   = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          txd_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs; reset forces the line high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SEQ_UART_TX_PARITY_EN
  // Latched copy of the accepted word, source of the parity bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else      data_q <= data_d;
  end
`endif

endmodule

// File: doc/seq_uart_tx.md
# seq_uart_tx

Serial UART transmitter on the output side of the sequencer's send path. Accepts one byte per handshake from the sequencer (data plus valid, gated by busy) and shifts it out LSB-first as an 8N1 frame on a single idle-high line. Drives the busy flag the sequencer uses to gate its send instruction, closing the loop between instruction execution and the board's UART pin.

## Interface
- CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200); legal range is 2 or more.
- DATA_WIDTH, default 8 (seq_dp_width), payload bits per frame.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- i_tx_data  input  DATA_WIDTH  byte to send; sampled only on the accept cycle.
- i_tx_valid  input  1  send request.
- o_tx_busy  output  1  frame in progress; registered. Must never depend combinationally on i_tx_valid, because the sequencer's valid depends on busy.
- o_txd  output  1  serial line; registered, idle high.

## Operation
- Accept: a rising edge where i_tx_valid=1 and o_tx_busy=0 latches i_tx_data into the shift register.
- Request ignored: i_tx_valid while o_tx_busy=1 is ignored, with no queuing.
- FSM IDLE: o_txd=1, o_tx_busy=0. On accept, go to START.
- FSM START: o_txd=0 for CLKS_PER_BIT cycles, then DATA.
- FSM DATA: o_txd=shift[0], each bit for CLKS_PER_BIT cycles, LSB first. Shift right after each bit. After DATA_WIDTH bits, go to PARITY (if enabled) or STOP.
- FSM PARITY: o_txd=^data for CLKS_PER_BIT cycles, then STOP.
- FSM STOP: o_txd=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is cleared on accept; a bit advances when it reaches CLKS_PER_BIT-1. Counter width is $clog2(CLKS_PER_BIT).
- Bit counter: counts 0..DATA_WIDTH-1 in DATA. Width is $clog2(DATA_WIDTH)+1, with no wrap beyond DATA_WIDTH-1.
- Reset values: o_txd=1, o_tx_busy=0, state=IDLE, counters=0, shift register=0.
- Reset mid-frame: the line returns high immediately (asynchronously). The partial frame is abandoned and is not resumed after reset.

## Timing
- Accept at edge k: o_txd falls and o_tx_busy rises at edge k (visible in cycle k+1).
- Busy duration: o_tx_busy stays high for exactly F*CLKS_PER_BIT cycles, where F=10 (F=11 with parity).
- Data bit n: occupies cycles k+1+(n+1)*CLKS_PER_BIT through k+(n+2)*CLKS_PER_BIT.
- Busy fall: o_tx_busy falls at the same edge the stop bit completes.
- Back-to-back: the first cycle with busy=0 may accept again, so the minimum frame-to-frame spacing is F*CLKS_PER_BIT+1 cycles.
- Idle gap: the stop level and idle level are both high, so no glitch appears on o_txd between frames.
- Simultaneous events: valid arriving on the same edge busy falls is not accepted, because busy is registered and still high at that edge. It is accepted on the next edge if valid is held.

## Configuration
- SEQ_UART_TX_PARITY_EN undefined: 8N1 frame, no PARITY state, F=10.
- SEQ_UART_TX_PARITY_EN defined: 8E1 frame, F=11. The even-parity bit (XOR of the latched data) is inserted between the last data bit and stop.
- Parity source: computed from the latched copy of the data, never from live i_tx_data.

## Structure
- Shared constants in seq_definitions.v: FSM state encodings (IDLE, START, DATA, PARITY, STOP), the default CLKS_PER_BIT, and the seq_dp_width reuse for DATA_WIDTH.
- Sub-module seq_uart_baud: baud counter with clear input and bit-tick output, parameterised by CLKS_PER_BIT. The top level holds the FSM, shift register and bit counter.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: rst=0 for 3 cycles, then released → o_txd=1, o_tx_busy=0; no activity for 50 cycles with i_tx_valid=0.
- Single byte: send 8'hA5 → line reads 0,1,0,1,0,0,1,0,1,1 in bits (start, LSB-first data, stop), each exactly 4 cycles; busy high for exactly 40 cycles.
- Back-to-back: hold valid with 8'h00 then 8'hFF → second start bit begins exactly 41 cycles after the first.
- Ignored request: pulse valid with 8'h3C mid-frame of 8'h55 → the 8'h55 frame is unaltered and no second frame is sent.
- Reset mid-frame: assert rst during data bit 3 → o_txd=1 and busy=0 asynchronously; after release, a new 8'h81 frame is correct.
- Parity (SEQ_UART_TX_PARITY_EN defined): 8'h07 → parity bit 1; 8'h03 → parity bit 0; busy high for 44 cycles each.
